window_buffer: RTL

Parametrised KxK sliding-window generator for the edge-detection video path, sitting between the AXI4-Stream pixel source and the convolution/filter stage. It stores K-1 previous lines in on-chip line buffers and emits one full KxK pixel window per accepted input pixel once the window lies entirely inside the frame. It supports full AXI4-Stream backpressure, frame resynchronisation on tuser, and the full tuser/tlast sideband mapped to window positions.

---
 rtl/window_pkg.sv | 32 +++
 rtl/line_fifo.sv | 36 +++
 rtl/window_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_pkg
// Description : Shared types and helpers for the KxK sliding-window generator:
//               frame-tracking state encoding, counter width helper and the
//               pixel slot index helper for the flattened window bus.
// Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    // Frame-tracking states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Largest supported window edge.
    localparam int c_KSIZE_MAX = 7;

    // Bits needed to address 0..depth-1 (never less than one bit).
    function automatic int col_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // LSB of pixel (r,c) inside the flattened window; r=0 top, c=0 left.
    function automatic int win_lsb(input int r, input int c, input int k, input int pw);
        return (r * k + c) * pw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : line_fifo
// Description : One video line of storage (DEPTH x PIX_W). Asynchronous read
//               at the current column with a write to the same column on the
//               enable edge, so the read returns the previous line's pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module line_fifo
    import window_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = col_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    output logic [PIX_W-1:0]  o_rd_data
);

    logic [PIX_W-1:0] r_mem [0:DEPTH-1];

    // Old contents are visible during the cycle the new pixel is written.
    assign o_rd_data = r_mem[i_addr];

    // Store the incoming pixel at the current column on each accepted beat.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_buffer
// Description : KxK sliding-window generator between an AXI4-Stream pixel
//               source and a filter stage. KSIZE-1 cascaded line buffers plus
//               KSIZE column shift registers build one window per accepted
//               pixel once the window lies fully inside the frame.
//               Optional macro WINDOW_LINE_ERR_EN enables the sticky
//               line-length error flag; otherwise line_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module window_buffer
    import window_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int KSIZE = 3
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic [PIX_W-1:0]             s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tuser,
    input  logic                         s_axis_tlast,
    output logic [PIX_W*KSIZE*KSIZE-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         line_err
);

    localparam int c_COL_W = col_width(IMG_W);
    localparam int c_ROW_W = col_width(KSIZE);
    localparam int c_WIN_W = PIX_W * KSIZE * KSIZE;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_EMIT = c_COL_W'(KSIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(KSIZE - 1);

    state_t               r_state, w_state_nxt;
    logic [c_COL_W-1:0]   r_col, w_col_cur, w_col_nxt;
    logic [c_ROW_W-1:0]   r_row, w_row_cur, w_row_nxt;
    logic                 r_first_pend, w_first_nxt;
    logic                 w_accept, w_track, w_eol, w_emit;
    logic [c_WIN_W-1:0]   r_win, w_win_nxt;
    logic [PIX_W-1:0]     w_lb_in [0:KSIZE-2];
    logic [PIX_W-1:0]     w_tap   [0:KSIZE-2];

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    // Pixels count only inside a frame; tuser always (re)starts one.
    assign w_track       = w_accept && (s_axis_tuser || (r_state != IDLE));
    assign w_col_cur     = s_axis_tuser ? '0 : r_col;
    assign w_row_cur     = s_axis_tuser ? '0 : r_row;
    assign w_eol         = s_axis_tlast || (w_col_cur == c_COL_LAST);
    assign w_emit        = w_track && (w_row_cur == c_ROW_LAST) && (w_col_cur >= c_COL_EMIT);

    // Next-state, position counters and first-window flag.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_first_nxt = r_first_pend;
        if (w_track) begin
            if (w_eol) begin
                w_col_nxt = '0;
                w_row_nxt = (w_row_cur == c_ROW_LAST) ? w_row_cur : w_row_cur + c_ROW_W'(1);
            end else begin
                w_col_nxt = w_col_cur + c_COL_W'(1);
                w_row_nxt = w_row_cur;
            end
            w_state_nxt = (w_row_nxt == c_ROW_LAST) ? RUN : FILL;
            if (s_axis_tuser) begin
                w_first_nxt = 1'b1;
            end else if (w_emit) begin
                w_first_nxt = 1'b0;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_first_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_first_pend <= w_first_nxt;
        end
    end

    // Cascaded line buffers: each one's old pixel feeds the next one's input.
    generate
        for (genvar i = 0; i < KSIZE - 1; i++) begin : g_line
            if (i == 0) begin : g_head
                assign w_lb_in[i] = s_axis_tdata;
            end else begin : g_link
                assign w_lb_in[i] = w_tap[i-1];
            end
            line_fifo #(
                .PIX_W  (PIX_W),
                .DEPTH  (IMG_W),
                .ADDR_W (c_COL_W)
            ) u_line (
                .clk       (aclk),
                .i_en      (w_track),
                .i_addr    (w_col_cur),
                .i_wr_data (w_lb_in[i]),
                .o_rd_data (w_tap[i])
            );
        end
    endgenerate

    // Window after shifting in the new column: taps on top, live pixel bottom.
    generate
        for (genvar r = 0; r < KSIZE; r++) begin : g_row
            for (genvar c = 0; c < KSIZE; c++) begin : g_col
                if (c < KSIZE - 1) begin : g_shift
                    assign w_win_nxt[win_lsb(r, c, KSIZE, PIX_W) +: PIX_W] =
                        r_win[win_lsb(r, c + 1, KSIZE, PIX_W) +: PIX_W];
                end else if (r == KSIZE - 1) begin : g_pix
                    assign w_win_nxt[win_lsb(r, c, KSIZE, PIX_W) +: PIX_W] = s_axis_tdata;
                end else begin : g_tap
                    assign w_win_nxt[win_lsb(r, c, KSIZE, PIX_W) +: PIX_W] = w_tap[KSIZE-2-r];
                end
            end
        end
    endgenerate

    // Column shift registers advance on every in-frame pixel.
    always_ff @(posedge aclk) begin
        if (w_track) begin
            r_win <= w_win_nxt;
        end
    end

    // Output register: load on emission, retire on downstream ready.
    always_ff @(posedge aclk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (w_emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_win_nxt;
            m_axis_tuser  <= r_first_pend;
            m_axis_tlast  <= w_eol;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef WINDOW_LINE_ERR_EN
    logic r_line_err;

    // Sticky flag: tlast and the last-column position must coincide.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_line_err <= 1'b0;
        end else if (w_track && (s_axis_tlast != (w_col_cur == c_COL_LAST))) begin
            r_line_err <= 1'b1;
        end
    end

    assign line_err = r_line_err;
`else
    assign line_err = 1'b0;
`endif

endmodule
`default_nettype wire
